phys_reg_bank: RTL and testbench

PHYS_REG_BANK -- requirements
Module: phys_reg_bank

---
 rtl/phys_reg_bank.sv | 98 +++++++++
 tb/tb_phys_reg_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_bank.sv
// Physical register bank: data + ready bit per entry, NWB write-back
// ports, NRD combinational read ports and a registered pending count.
// Ports: clk, reset (async, active-low), alloc_en/alloc_tag,
//   wb_en/wb_tag/wb_data, rd_tag -> rd_data/rd_ready, pending_cnt.
// Option: PHYS_REG_BANK_BYPASS_EN forwards same-cycle write-back to reads.
module phys_reg_bank #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 32,
  parameter  int NWB   = 2,
  parameter  int NRD   = 2,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [TW-1:0]        alloc_tag,
  input  logic [NWB-1:0]       wb_en,
  input  logic [NWB*TW-1:0]    wb_tag,
  input  logic [NWB*WIDTH-1:0] wb_data,
  input  logic [NRD*TW-1:0]    rd_tag,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_ready,
  output logic [TW:0]          pending_cnt
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_ready;
  logic [TW:0]      r_cnt;

  logic [DEPTH-1:0] w_we;
  logic [WIDTH-1:0] w_wd [DEPTH];
  logic [DEPTH-1:0] w_rdy_nxt;
  logic [TW:0]      w_cnt_nxt;

  // Ports scanned high to low so the lowest port wins a tag clash.
  // Alloc is applied last so it owns the ready bit.
  always_comb begin
    w_we      = '0;
    w_rdy_nxt = r_ready;
    w_cnt_nxt = '0;
    for (int t = 0; t < DEPTH; t++) begin
      w_wd[t] = '0;
      for (int p = NWB - 1; p >= 0; p--) begin
        if (t != 0 && wb_en[p] &&
            wb_tag[p*TW +: TW] == TW'(t)) begin
          w_we[t] = 1'b1;
          w_wd[t] = wb_data[p*WIDTH +: WIDTH];
        end
      end
      if (w_we[t])
        w_rdy_nxt[t] = 1'b1;
      if (t != 0 && alloc_en && alloc_tag == TW'(t))
        w_rdy_nxt[t] = 1'b0;
      w_cnt_nxt = w_cnt_nxt + {{TW{1'b0}}, ~w_rdy_nxt[t]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < DEPTH; t++)
        r_data[t] <= '0;
      r_ready <= '1;
      r_cnt   <= '0;
    end else begin
      for (int t = 0; t < DEPTH; t++)
        if (w_we[t])
          r_data[t] <= w_wd[t];
      r_ready <= w_rdy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int r = 0; r < NRD; r++) begin
      if (rd_tag[r*TW +: TW] == '0) begin
        rd_data[r*WIDTH +: WIDTH] = '0;
        rd_ready[r]               = 1'b1;
      end else begin
        rd_data[r*WIDTH +: WIDTH] = r_data[rd_tag[r*TW +: TW]];
        rd_ready[r]               = r_ready[rd_tag[r*TW +: TW]];
`ifdef PHYS_REG_BANK_BYPASS_EN
        for (int p = NWB - 1; p >= 0; p--) begin
          if (wb_en[p] &&
              wb_tag[p*TW +: TW] == rd_tag[r*TW +: TW]) begin
            rd_data[r*WIDTH +: WIDTH] = wb_data[p*WIDTH +: WIDTH];
            rd_ready[r]               = 1'b1;
          end
        end
`endif
      end
    end
  end

  assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_phys_reg_bank.sv
// Directed bench for phys_reg_bank (default parameters).
// Expected values are hand-computed constants.
module tb_phys_reg_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic         alloc_en;
  logic [4:0]   alloc_tag;
  logic [1:0]   wb_en;
  logic [9:0]   wb_tag;
  logic [127:0] wb_data;
  logic [9:0]   rd_tag;
  logic [127:0] rd_data;
  logic [1:0]   rd_ready;
  logic [5:0]   pending_cnt;

  int total = 0;
  int bad   = 0;

  phys_reg_bank dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (alloc_tag),
    .wb_en       (wb_en),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en = 1'b0;
    wb_en    = '0;
  endtask

  task automatic rd(input int p, input int t);
    rd_tag[p*5 +: 5] = 5'(t);
    #1;
  endtask

  task automatic wb(input int p, input int t, input logic [63:0] d);
    wb_en[p]            = 1'b1;
    wb_tag[p*5 +: 5]    = 5'(t);
    wb_data[p*64 +: 64] = d;
  endtask

  function automatic logic [63:0] dat(input int p);
    return rd_data[p*64 +: 64];
  endfunction

  initial begin
    reset     = 1'b0;
    alloc_en  = 1'b0;
    alloc_tag = '0;
    wb_en     = '0;
    wb_tag    = '0;
    wb_data   = '0;
    rd_tag    = '0;
    #2;
    chk("rst_cnt", 64'(pending_cnt), 64'd0);
    tick();
    reset = 1'b1;
    for (int t = 0; t < 32; t++) begin
      rd(0, t);
      rd(1, 31 - t);
      chk("init_d0", dat(0), 64'd0);
      chk("init_r0", 64'(rd_ready[0]), 64'd1);
      chk("init_d1", dat(1), 64'd0);
      chk("init_r1", 64'(rd_ready[1]), 64'd1);
    end
    chk("init_cnt", 64'(pending_cnt), 64'd0);

    alloc_en = 1'b1; alloc_tag = 5'd5;
    tick(); idle();
    rd(0, 5);
    chk("a5_rdy", 64'(rd_ready[0]), 64'd0);
    chk("a5_cnt", 64'(pending_cnt), 64'd1);
    wb(0, 5, 64'hDEAD_BEEF);
    tick(); idle();
    rd(0, 5);
    chk("w5_dat", dat(0), 64'hDEAD_BEEF);
    chk("w5_rdy", 64'(rd_ready[0]), 64'd1);
    chk("w5_cnt", 64'(pending_cnt), 64'd0);

    wb(0, 7, 64'h11); wb(1, 7, 64'h22);
    tick(); idle();
    rd(1, 7);
    chk("p0win", dat(1), 64'h11);
    chk("p0win_rdy", 64'(rd_ready[1]), 64'd1);

    alloc_en = 1'b1; alloc_tag = 5'd9;
    wb(1, 9, 64'h33);
    tick(); idle();
    rd(0, 9);
    chk("aw9_dat", dat(0), 64'h33);
    chk("aw9_rdy", 64'(rd_ready[0]), 64'd0);
    chk("aw9_cnt", 64'(pending_cnt), 64'd1);

    alloc_en = 1'b1; alloc_tag = 5'd0;
    wb(0, 0, 64'hFF);
    tick(); idle();
    rd(0, 0);
    chk("t0_dat", dat(0), 64'd0);
    chk("t0_rdy", 64'(rd_ready[0]), 64'd1);
    chk("t0_cnt", 64'(pending_cnt), 64'd1);

    alloc_en = 1'b1; alloc_tag = 5'd9;
    wb(0, 7, 64'h44);
    tick(); idle();
    rd(0, 7);
    chk("dbl_cnt", 64'(pending_cnt), 64'd1);
    chk("rewr7", dat(0), 64'h44);

    for (int t = 1; t < 32; t++) begin
      alloc_en = 1'b1; alloc_tag = 5'(t);
      tick();
    end
    idle();
    #1;
    chk("all_cnt", 64'(pending_cnt), 64'd31);

    wb(0, 10, 64'h5);
    tick(); idle();
    chk("w10_cnt", 64'(pending_cnt), 64'd30);

    rd(1, 3);
    wb(1, 3, 64'hAB);
    #1;
`ifdef PHYS_REG_BANK_BYPASS_EN
    chk("byp_dat", dat(1), 64'hAB);
    chk("byp_rdy", 64'(rd_ready[1]), 64'd1);
`else
    chk("nobyp_dat", dat(1), 64'd0);
    chk("nobyp_rdy", 64'(rd_ready[1]), 64'd0);
`endif
    tick(); idle();
    #1;
    chk("w3_dat", dat(1), 64'hAB);
    chk("w3_rdy", 64'(rd_ready[1]), 64'd1);
    chk("w3_cnt", 64'(pending_cnt), 64'd29);

    rd(0, 7);
    rd(1, 9);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_cnt", 64'(pending_cnt), 64'd0);
    chk("mrst_d7", dat(0), 64'd0);
    chk("mrst_r9", 64'(rd_ready[1]), 64'd1);
    alloc_en = 1'b1; alloc_tag = 5'd4;
    wb(0, 7, 64'h99);
    tick();
    chk("rst_ign_cnt", 64'(pending_cnt), 64'd0);
    chk("rst_ign_d7", dat(0), 64'd0);
    reset = 1'b1;
    wb_en = '0;
    tick(); idle();
    rd(1, 4);
    chk("rel_cnt", 64'(pending_cnt), 64'd1);
    chk("rel_r4", 64'(rd_ready[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
